feed_replay_src: RTL and testbench

- Synthesizable Avalon-ST stimulus source that replays a loaded sequence of recorded feed beats into feed_decoder (or any Avalon-ST sink) at line rate.
- Each stored beat carries data, framing, empty and a pre-beat idle-gap count, reproducing recorded inter-beat timing.
- Generalises the file-driven replay: parametrised width/depth, honours out_ready backpressure, supports single-shot or N-loop replay, and is usable on hardware as well as in simulation.

---
 rtl/feed_replay_pkg.sv | 17 +
 rtl/feed_replay_if.sv | 13 +
 rtl/feed_replay_ram.sv | 20 ++
 rtl/feed_replay_src.sv | 159 +++++++++++++++
 tb/tb_feed_replay_src.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/feed_replay_pkg.sv
// feed_replay_pkg: shared state/beat types and default sizes for the feed replay source
package feed_replay_pkg;
  localparam int RP_DATA_W = 64;
  localparam int RP_EMPTY_W = $clog2(RP_DATA_W / 8);
  localparam int RP_DEPTH = 1024;
  localparam int RP_GAP_W = 8;
  localparam int RP_LOOP_W = 16;
  localparam int REPLAY_ERR_CNT_W = 16;
  typedef enum logic [2:0] {IDLE, FETCH, GAP, SEND, DONE} replay_state_e;
  typedef struct packed {
    logic sop;
    logic eop;
    logic [RP_EMPTY_W-1:0] empty;
    logic [RP_GAP_W-1:0] gap;
    logic [RP_DATA_W-1:0] data;
  } replay_beat_t;
endpackage

// File: rtl/feed_replay_if.sv
// feed_replay_if: Avalon-ST stream from the replay source to its sink
interface feed_replay_if #(parameter int DATA_W = 64);
  localparam int EMPTY_W = $clog2(DATA_W / 8);
  logic out_valid;
  logic out_ready;
  logic out_startofpacket;
  logic out_endofpacket;
  logic [DATA_W-1:0] out_data;
  logic [EMPTY_W-1:0] out_empty;
  logic out_error;
  modport master(output out_valid, out_startofpacket, out_endofpacket, out_data, out_empty, out_error, input out_ready);
  modport slave(input out_valid, out_startofpacket, out_endofpacket, out_data, out_empty, out_error, output out_ready);
endinterface

// File: rtl/feed_replay_ram.sv
// feed_replay_ram: beat store with one write port and one registered read port (block RAM style)
module feed_replay_ram #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  // write on load, always read the requested entry one cycle later
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/feed_replay_src.sv
// feed_replay_src: replays stored Avalon-ST beats with recorded idle gaps; define FEED_REPLAY_FRAME_CHECK_EN for load-side framing check
module feed_replay_src
  import feed_replay_pkg::*;
#(
  parameter int DATA_W = RP_DATA_W,
  parameter int DEPTH = RP_DEPTH,
  parameter int GAP_W = RP_GAP_W,
  parameter int LOOP_W = RP_LOOP_W,
  localparam int EMPTY_W = $clog2(DATA_W / 8),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic                        ld_sop,
  input  logic                        ld_eop,
  input  logic [DATA_W-1:0]           ld_data,
  input  logic [EMPTY_W-1:0]          ld_empty,
  input  logic [GAP_W-1:0]            ld_gap,
  input  logic                        ld_clear,
  input  logic                        start,
  input  logic                        stop,
  input  logic [LOOP_W-1:0]           loops,
  output logic                        busy,
  output logic                        done,
  output logic [AW:0]                 num_entries,
  output logic [REPLAY_ERR_CNT_W-1:0] frame_err_cnt,
  feed_replay_if.master               src
);
  localparam int OW = 2 + EMPTY_W + DATA_W;
  localparam int BW = OW + GAP_W;
  replay_state_e state_q, state_d;
  logic [AW:0] num_q, num_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, ptr_nxt, rd_addr;
  logic [GAP_W-1:0] gap_q, gap_d, ram_gap;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [OW-1:0] cur_q, cur_d, ram_beat;
  logic [BW-1:0] ram_q;
  logic [REPLAY_ERR_CNT_W-1:0] err_q, err_d;
  logic stop_q, stop_d, open_q, open_d, ld_open_q, ld_open_d;
  logic ld_store, viol, last, cur_sop, cur_eop;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p, input logic [AW:0] n);
    return ({1'b0, p} + (AW+1)'(1) >= n) ? '0 : p + AW'(1);
  endfunction

`ifdef FEED_REPLAY_FRAME_CHECK_EN
  assign viol = ld_sop == ld_open_q;
  assign frame_err_cnt = err_q;
`else
  assign viol = 1'b0;
  assign frame_err_cnt = '0;
`endif

  assign ld_ready = state_q == IDLE && num_q < (AW+1)'(DEPTH) && !ld_clear;
  assign num_entries = num_q;
  assign busy = state_q == FETCH || state_q == GAP || state_q == SEND;
  assign done = state_q == DONE;
  assign ram_gap = ram_q[DATA_W +: GAP_W];
  assign ram_beat = {ram_q[BW-1 -: 2+EMPTY_W], ram_q[DATA_W-1:0]};
  assign cur_sop = cur_q[OW-1];
  assign cur_eop = cur_q[OW-2];
  assign ptr_nxt = wrap_inc(rd_ptr_q, num_q);
  assign last = {1'b0, rd_ptr_q} + (AW+1)'(1) >= num_q;
  assign rd_addr = state_q == IDLE ? '0 : wrap_inc(rd_ptr_d, num_q);
  assign src.out_valid = state_q == SEND;
  assign src.out_startofpacket = cur_sop;
  assign src.out_endofpacket = cur_eop;
  assign src.out_empty = cur_q[DATA_W +: EMPTY_W];
  assign src.out_data = cur_q[DATA_W-1:0];
  assign src.out_error = 1'b0;

  feed_replay_ram #(.W(BW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ld_store),
    .waddr (num_q[AW-1:0]),
    .wdata ({ld_sop, ld_eop, ld_empty, ld_gap, ld_data}),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // load side: append accepted beats, clear wins, framing violations are counted but dropped
  always_comb begin
    ld_store = ld_valid && ld_ready && !viol;
    num_d = ld_clear ? '0 : num_q + {{AW{1'b0}}, ld_store};
    ld_open_d = ld_clear ? 1'b0 : ld_store ? !ld_eop : ld_open_q;
    err_d = ld_clear ? '0 : (ld_valid && ld_ready && viol && err_q != '1) ? err_q + REPLAY_ERR_CNT_W'(1) : err_q;
  end

  // replay sequencer: prefetching the next entry keeps one beat per cycle when gaps are zero
  always_comb begin
    state_d = state_q;
    rd_ptr_d = rd_ptr_q;
    gap_d = gap_q;
    loop_d = loop_q;
    cur_d = cur_q;
    open_d = open_q;
    stop_d = stop_q || (stop && busy);
    case (state_q)
      IDLE: if (start) begin
        state_d = num_q != '0 ? FETCH : DONE;
        rd_ptr_d = '0;
        loop_d = loops;
        open_d = 1'b0;
      end
      FETCH: begin
        cur_d = ram_beat;
        gap_d = ram_gap;
        state_d = ram_gap != '0 ? GAP : SEND;
      end
      GAP: begin
        gap_d = gap_q - GAP_W'(1);
        state_d = gap_q == GAP_W'(1) ? SEND : GAP;
      end
      SEND: if (src.out_ready) begin
        open_d = !cur_eop && (cur_sop || open_q);
        rd_ptr_d = ptr_nxt;
        cur_d = ram_beat;
        gap_d = ram_gap;
        loop_d = last ? loop_q - LOOP_W'(1) : loop_q;
        state_d = (cur_eop && stop_q) || (last && loop_q == '0) ? DONE : ram_gap != '0 ? GAP : SEND;
      end
      DONE: begin
        state_d = IDLE;
        stop_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (stop_q && !open_q && (state_q == FETCH || state_q == GAP || (state_q == SEND && !src.out_ready))) state_d = DONE;
  end

  // state registers; stored beats themselves survive reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      num_q <= '0;
      rd_ptr_q <= '0;
      gap_q <= '0;
      loop_q <= '0;
      cur_q <= '0;
      err_q <= '0;
      stop_q <= 1'b0;
      open_q <= 1'b0;
      ld_open_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q <= num_d;
      rd_ptr_q <= rd_ptr_d;
      gap_q <= gap_d;
      loop_q <= loop_d;
      cur_q <= cur_d;
      err_q <= err_d;
      stop_q <= stop_d;
      open_q <= open_d;
      ld_open_q <= ld_open_d;
    end
  end
endmodule

// File: tb/tb_feed_replay_src.sv
// tb_feed_replay_src: randomized replay checks against a beat-list reference model
module tb_feed_replay_src;
  localparam int DW = 64;
  localparam int DEPTH = 8;
  localparam int GW = 8;
  localparam int LW = 16;
  localparam int EW = 3;
  localparam int AW = 3;
  typedef struct {
    logic sop;
    logic eop;
    logic [EW-1:0] empty;
    int gap;
    logic [DW-1:0] data;
  } beat_t;
  logic clk = 0;
  logic reset_n = 0;
  logic ld_valid = 0, ld_sop = 0, ld_eop = 0, ld_clear = 0, start = 0, stop = 0;
  logic [DW-1:0] ld_data = '0;
  logic [EW-1:0] ld_empty = '0;
  logic [GW-1:0] ld_gap = '0;
  logic [LW-1:0] loops = '0;
  logic ld_ready, busy, done;
  logic [AW:0] num_entries;
  logic [15:0] frame_err_cnt;
  int n_chk = 0, n_pass = 0, cyc = 0, ready_mode = 0, m_err = 0;
  bit m_open = 0;
  bit hold = 0;
  logic [68:0] hold_vec;
  beat_t tbl[$];
  logic [68:0] got[$];
  int got_cyc[$];
  int done_cyc[$];

  feed_replay_if #(.DATA_W(DW)) bus ();

  feed_replay_src #(.DATA_W(DW), .DEPTH(DEPTH), .GAP_W(GW), .LOOP_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sop(ld_sop),
    .ld_eop(ld_eop), .ld_data(ld_data), .ld_empty(ld_empty), .ld_gap(ld_gap), .ld_clear(ld_clear),
    .start(start), .stop(stop), .loops(loops), .busy(busy), .done(done), .num_entries(num_entries),
    .frame_err_cnt(frame_err_cnt), .src(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [68:0] pack(input beat_t b);
    return {b.sop, b.eop, b.empty, b.data};
  endfunction

  task automatic check(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
    n_chk++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
  endtask

  // stream monitor: records handshakes and done pulses, checks beats hold while stalled
  always @(negedge clk) begin
    if (reset_n) begin
      if (hold) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_beat", {bus.out_startofpacket, bus.out_endofpacket, bus.out_empty, bus.out_data}, hold_vec);
      end
      if (bus.out_valid && bus.out_ready) begin
        got.push_back({bus.out_startofpacket, bus.out_endofpacket, bus.out_empty, bus.out_data});
        got_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
      hold = bus.out_valid && !bus.out_ready;
      hold_vec = {bus.out_startofpacket, bus.out_endofpacket, bus.out_empty, bus.out_data};
    end else hold = 0;
  end

  initial begin
    bus.out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? !bus.out_ready : 1'($urandom & 1);
    end
  end

  task automatic load(input logic sop, input logic eop, input logic [EW-1:0] emp, input int gap, input logic [DW-1:0] d);
    beat_t b;
    bit ok = 1;
    @(posedge clk);
    #1;
    ld_valid = 1; ld_sop = sop; ld_eop = eop; ld_empty = emp; ld_gap = GW'(gap); ld_data = d;
    @(negedge clk);
    check("ld_ready", ld_ready, 1);
    @(posedge clk);
    #1;
    ld_valid = 0;
`ifdef FEED_REPLAY_FRAME_CHECK_EN
    ok = sop != m_open;
    if (!ok) m_err++;
    else m_open = !eop;
`endif
    b.sop = sop; b.eop = eop; b.empty = emp; b.gap = gap; b.data = d;
    if (ok) tbl.push_back(b);
    check("num_entries", num_entries, tbl.size());
    check("frame_err", frame_err_cnt, m_err);
  endtask

  task automatic clear_tbl();
    @(posedge clk);
    #1;
    ld_clear = 1;
    @(posedge clk);
    #1;
    ld_clear = 0;
    tbl.delete();
    m_open = 0;
    m_err = 0;
    check("clear_num", num_entries, 0);
    check("clear_err", frame_err_cnt, 0);
  endtask

  task automatic replay(input int nloops, input int mode, input int stop_at);
    beat_t exp[$];
    int st, k, n = 0, rel = 1;
    bit stopped = 0;
    ready_mode = mode;
    for (int p = 0; p <= nloops; p++) foreach (tbl[i]) exp.push_back(tbl[i]);
    if (stop_at >= 0) begin
      k = stop_at;
      while (k < exp.size() && !exp[k].eop) k++;
      while (exp.size() > k + 1) void'(exp.pop_back());
    end
    got.delete(); got_cyc.delete(); done_cyc.delete();
    @(posedge clk);
    #1;
    loops = LW'(nloops);
    start = 1;
    st = cyc;
    @(posedge clk);
    #1;
    start = 0;
    while (done_cyc.size() == 0 && n < 4000) begin
      @(negedge clk);
      n++;
      if (n == 1 && tbl.size() > 0) check("ld_ready_busy", ld_ready, 0);
      if (stop_at >= 0 && !stopped && got.size() == stop_at) begin
        @(posedge clk);
        #1;
        stop = 1;
        @(posedge clk);
        #1;
        stop = 0;
        stopped = 1;
      end
    end
    check("done_seen", done_cyc.size() != 0, 1);
    repeat (4) @(negedge clk);
    check("done_once", done_cyc.size(), 1);
    check("busy_idle", busy, 0);
    check("beat_count", got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("beat%0d", i), got[i], pack(exp[i]));
      if (mode == 0 && stop_at < 0) begin
        rel += exp[i].gap + 1;
        check($sformatf("beat%0d_cyc", i), got_cyc[i] - st, rel);
      end
    end
    if (mode == 0 && stop_at < 0 && done_cyc.size() > 0) check("done_cyc", done_cyc[0] - st, exp.size() > 0 ? rel + 1 : 1);
  endtask

  task automatic load_three(input int gap1);
    load(1, 0, 0, 0, 64'h1111_0000_0000_0001);
    load(0, 0, 0, gap1, 64'h2222_0000_0000_0002);
    load(0, 1, 3, 0, 64'h3333_0000_0000_0003);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_num", num_entries, 0);
    check("rst_err", frame_err_cnt, 0);
    check("rst_ld_ready", ld_ready, 1);
    @(posedge clk);
    #1;
    reset_n = 1;
    replay(0, 0, -1);
    load_three(0);
    replay(0, 0, -1);
    clear_tbl();
    load_three(4);
    replay(0, 0, -1);
    clear_tbl();
    load_three(0);
    replay(0, 1, -1);
    clear_tbl();
    load(1, 0, 0, 0, 64'hA0A0);
    load(0, 1, 5, 0, 64'hB1B1);
    replay(2, 0, -1);
    clear_tbl();
    for (int i = 0; i < 4; i++) load(i == 0, i == 3, 3'(i), 0, 64'(i + 'h40));
    replay(5, 0, 1);
    @(posedge clk);
    #1;
    ld_valid = 1; ld_clear = 1; ld_sop = 1; ld_eop = 1;
    @(negedge clk);
    check("clear_blocks_ready", ld_ready, 0);
    @(posedge clk);
    #1;
    ld_valid = 0; ld_clear = 0;
    tbl.delete(); m_open = 0; m_err = 0;
    check("clear_prio_num", num_entries, 0);
    for (int r = 0; r < 8; r++) begin
      int n, len;
      clear_tbl();
      n = $urandom_range(1, DEPTH);
      while (tbl.size() < n) begin
        len = $urandom_range(1, 3);
        if (len > n - tbl.size()) len = n - tbl.size();
        for (int j = 0; j < len; j++)
          load(j == 0, j == len - 1, 3'($urandom), $urandom_range(0, 1) ? 0 : $urandom_range(1, 3), {$urandom, $urandom});
      end
      replay($urandom_range(0, 2), $urandom_range(0, 2), -1);
    end
    clear_tbl();
    for (int i = 0; i < DEPTH; i++) load(1, 1, 0, 0, 64'(i));
    @(posedge clk);
    #1;
    ld_valid = 1;
    @(negedge clk);
    check("full_ready", ld_ready, 0);
    check("full_num", num_entries, DEPTH);
    @(posedge clk);
    #1;
    ld_valid = 0;
`ifdef FEED_REPLAY_FRAME_CHECK_EN
    clear_tbl();
    load(0, 0, 0, 0, 64'hBAD0);
    load(1, 0, 0, 0, 64'hC001);
    load(1, 1, 0, 0, 64'hBAD1);
    load(0, 1, 2, 0, 64'hC002);
    replay(0, 0, -1);
`endif
    clear_tbl();
    for (int i = 0; i < 4; i++) load(i == 0, i == 3, 0, 0, 64'(i + 'h70));
    ready_mode = 0;
    @(posedge clk);
    #1;
    start = 1; loops = 0;
    @(posedge clk);
    #1;
    start = 0;
    done_cyc.delete();
    repeat (2) @(negedge clk);
    check("valid_pre_rst", bus.out_valid, 1);
    #2;
    reset_n = 0;
    #1;
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_num", num_entries, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    @(posedge clk);
    #1;
    reset_n = 1;
    tbl.delete(); m_open = 0; m_err = 0;
    repeat (3) @(negedge clk);
    check("no_done_after_rst", done_cyc.size(), 0);
    check("idle_after_rst", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
